regfile_arbiter: RTL and testbench

- Shares one single-port register file between NUM_REQ requesters, e.g. a pipeline port and a debug/DMA port.
- The register file has one address, combinational read data, and an active-low write enable. This block picks one requester per cycle by round-robin, with optional lock-based bursts.
- The accepted access is registered and then driven onto the regfile port in the following cycle. The block returns a registered ack and read data.
- Sits between the requesters and regfile; it is the only driver of the regfile port.

---
 rtl/regfile_arbiter_pkg.sv | 21 ++
 rtl/regfile_arbiter_rr_pick.sv | 45 ++++
 rtl/regfile_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// regfile_arbiter_pkg: regfile defaults and arbiter lock-state encodings. Rev 1.0
// -----------------------------------------------------------------------------
package regfile_arbiter_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DATA_D = 32;
   localparam int DEF_ADDR_W = 5;

   // Active-low write-enable levels of the regfile port
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [0:0] {
      ARB_OPEN   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_arbiter_rr_pick.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rr_pick: combinational round-robin picker starting at ptr, restricted by mask. Rev 1.0
// -----------------------------------------------------------------------------
module rr_pick
   import regfile_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic [NUM_REQ-1:0] mask,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               found
);

   logic [NUM_REQ-1:0] cand;

   assign cand = req & mask;

   // First pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && cand[j] && (j >= int'(ptr))) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && cand[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// regfile_arbiter: round-robin/lock arbiter in front of a single-port regfile. Rev 1.0
// -----------------------------------------------------------------------------
module regfile_arbiter
   import regfile_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DATA_D  = DEF_DATA_D
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        wr,
   input  logic [NUM_REQ-1:0]        lock,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         rf_addr,
   output logic [DATA_W-1:0]         rf_d_in,
   output logic                      rf_we_,
   input  logic [DATA_W-1:0]         rf_d_out
);

   localparam int              IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(DATA_D);

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   arb_state_e          state, state_nxt;
   logic [IDX_W-1:0]    owner, owner_nxt;
   logic [IDX_W-1:0]    ptr, ptr_nxt;
   logic [NUM_REQ-1:0]  mask;
   logic [NUM_REQ-1:0]  pick_gnt;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_found;
   logic                accept;

   logic                s_valid;
   logic                s_wr;
   logic [IDX_W-1:0]    s_idx;
   logic [ADDR_W-1:0]   s_addr;
   logic [DATA_W-1:0]   s_wdata;
   logic                addr_ok;

   assign mask = (state == ARB_LOCKED) ? (NUM_REQ'(1) << owner) : '1;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req   (req),
      .ptr   (ptr),
      .mask  (mask),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign gnt    = reset ? '0 : pick_gnt;
   assign accept = pick_found & ~reset;

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      case (state)
         ARB_OPEN: begin
            if (accept) begin
               ptr_nxt = next_idx(pick_idx);
               if (lock[pick_idx]) begin
                  state_nxt = ARB_LOCKED;
                  owner_nxt = pick_idx;
               end
            end
         end
         ARB_LOCKED: begin
            // Owner dropping req releases the lock even without an access
            if (!req[owner] || (accept && !lock[owner])) begin
               state_nxt = ARB_OPEN;
               ptr_nxt   = next_idx(owner);
            end
         end
         default: state_nxt = ARB_OPEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ARB_OPEN;
         owner <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_valid <= 1'b0;
         s_wr    <= 1'b0;
         s_idx   <= '0;
         s_addr  <= '0;
         s_wdata <= '0;
         ack     <= '0;
         rdata   <= '0;
      end else begin
         s_valid <= accept;
         if (accept) begin
            s_wr    <= wr[pick_idx];
            s_idx   <= pick_idx;
            s_addr  <= addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            s_wdata <= wdata[int'(pick_idx)*DATA_W +: DATA_W];
         end
         ack   <= s_valid ? (NUM_REQ'(1) << s_idx) : '0;
         rdata <= (s_valid && addr_ok) ? rf_d_out : '0;
      end
   end

   // Out-of-range accesses park the port on address 0 and never write
   assign addr_ok = ({1'b0, s_addr} < DEPTH);
   assign rf_addr = addr_ok ? s_addr : '0;
   assign rf_d_in = s_wdata;
   assign rf_we_  = (s_valid && s_wr && addr_ok && !reset) ? ENABLE_ : DISABLE_;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_regfile_arbiter: directed stimulus with a queue scoreboard for acks/rdata. Rev 1.0
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 32;
   localparam int DATA_D  = 16;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req, wr, lock;
   logic [NUM_REQ*ADDR_W-1:0] addr;
   logic [NUM_REQ*DATA_W-1:0] wdata;
   logic [NUM_REQ-1:0]        gnt, ack;
   logic [DATA_W-1:0]         rdata, rf_d_in, rf_d_out;
   logic [ADDR_W-1:0]         rf_addr;
   logic                      rf_we_;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic init_mem;

   logic [DATA_W-1:0] rf_mem  [0:31];
   logic [DATA_W-1:0] exp_mem [0:31];

   typedef struct {
      logic [NUM_REQ-1:0] oh;
      logic [DATA_W-1:0]  rd;
      int                 due;
   } exp_t;

   typedef struct {
      int                 idx;
      logic               wr;
      logic [ADDR_W-1:0]  addr;
      logic [DATA_W-1:0]  wdata;
   } pend_t;

   exp_t  sb[$];
   pend_t pend;
   logic  pend_v = 1'b0;

   regfile_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .DATA_D  (DATA_D)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .wr       (wr),
      .lock     (lock),
      .addr     (addr),
      .wdata    (wdata),
      .gnt      (gnt),
      .ack      (ack),
      .rdata    (rdata),
      .rf_addr  (rf_addr),
      .rf_d_in  (rf_d_in),
      .rf_we_   (rf_we_),
      .rf_d_out (rf_d_out)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] init_val(input int i);
      return (i == 3) ? 32'hDEAD_BEEF : 32'h1000_0000 + i;
   endfunction

   // Regfile model: combinational read, write on the clock edge
   assign rf_d_out = rf_mem[rf_addr];
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
      end else if (!rf_we_) begin
         rf_mem[rf_addr] <= rf_d_in;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard: accept -> regfile stage next cycle -> ack the cycle after
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         check("sb_ack", 64'(ack), 64'(e.oh));
         check("sb_rdata", 64'(rdata), 64'(e.rd));
      end else begin
         check("sb_no_ack", 64'(ack), 64'd0);
      end
      if (reset) begin
         pend_v = 1'b0;
      end else begin
         if (pend_v) begin
            e.oh  = NUM_REQ'(1) << pend.idx;
            e.due = cyc + 1;
            if (int'(pend.addr) < DATA_D) begin
               e.rd = exp_mem[pend.addr];
               if (pend.wr) exp_mem[pend.addr] = pend.wdata;
            end else begin
               e.rd = '0;
            end
            sb.push_back(e);
            pend_v = 1'b0;
         end
         if ((gnt & req) != '0) begin
            check("gnt_onehot", 64'($onehot(gnt)), 64'd1);
            for (int i = 0; i < NUM_REQ; i++) begin
               if (gnt[i]) begin
                  pend.idx   = i;
                  pend.wr    = wr[i];
                  pend.addr  = addr[i*ADDR_W +: ADDR_W];
                  pend.wdata = wdata[i*DATA_W +: DATA_W];
               end
            end
            pend_v = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic r, input logic w, input logic l,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req[i]                  = r;
      wr[i]                   = w;
      lock[i]                 = l;
      addr[i*ADDR_W +: ADDR_W] = a;
      wdata[i*DATA_W +: DATA_W] = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; req = '0; wr = '0; lock = '0; addr = '0; wdata = '0;
      init_mem = 1'b1;
      for (int i = 0; i < 32; i++) exp_mem[i] = init_val(i);
      step();
      init_mem = 1'b0;
      step();
      req = 2'b11;
      #3;
      check("rst_gnt",   64'(gnt),     64'd0);
      check("rst_we",    64'(rf_we_),  64'd1);
      check("rst_addr",  64'(rf_addr), 64'd0);
      check("rst_din",   64'(rf_d_in), 64'd0);
      check("rst_ack",   64'(ack),     64'd0);
      check("rst_rdata", 64'(rdata),   64'd0);

      // Single read of reg 3
      step(); reset = 1'b0; req = '0; drive(0, 1, 0, 0, 5'd3, '0);
      #3 check("t1_gnt", 64'(gnt), 64'b01);
      step(); drive(0, 0, 0, 0, '0, '0);
      #3 check("t1_rfaddr", 64'(rf_addr), 64'd3);
      check("t1_we", 64'(rf_we_), 64'd1);
      step();
      #3 check("t1_ack", 64'(ack), 64'b01);
      check("t1_rdata", 64'(rdata), 64'hDEAD_BEEF);

      // Write reg 5 then read it back-to-back
      step(); drive(0, 1, 1, 0, 5'd5, 32'h1234_5678);
      #3 check("t2_gnt_w", 64'(gnt), 64'b01);
      check("t2_we_idle", 64'(rf_we_), 64'd1);
      step(); drive(0, 1, 0, 0, 5'd5, '0);
      #3 check("t2_gnt_r", 64'(gnt), 64'b01);
      check("t2_we_low", 64'(rf_we_), 64'd0);
      check("t2_rfaddr", 64'(rf_addr), 64'd5);
      check("t2_din", 64'(rf_d_in), 64'h1234_5678);
      step(); drive(0, 0, 0, 0, '0, '0);
      #3 check("t2_we_high", 64'(rf_we_), 64'd1);
      check("t2_ack_w", 64'(ack), 64'b01);
      check("t2_old", 64'(rdata), 64'(init_val(5)));
      step();
      #3 check("t2_ack_r", 64'(ack), 64'b01);
      check("t2_new", 64'(rdata), 64'h1234_5678);

      // Round-robin with both requesting from reset
      step(); reset = 1'b1; drive(0, 1, 0, 0, 5'd1, '0); drive(1, 1, 0, 0, 5'd2, '0);
      #3 check("t3_rst_gnt", 64'(gnt), 64'd0);
      step(); reset = 1'b0;
      #3 check("t3_g0", 64'(gnt), 64'b01);
      step();
      #3 check("t3_g1", 64'(gnt), 64'b10);
      step();
      #3 check("t3_g2", 64'(gnt), 64'b01);
      check("t3_a0", 64'(ack), 64'b01);
      step();
      #3 check("t3_g3", 64'(gnt), 64'b10);
      check("t3_a1", 64'(ack), 64'b10);
      step(); req = '0;
      #3 check("t3_a2", 64'(ack), 64'b01);
      step();
      #3 check("t3_a3", 64'(ack), 64'b10);
      step();

      // Lock burst by requester 1 while requester 0 waits
      step(); drive(0, 1, 0, 0, 5'd9, '0);
      #3 check("t4_pre", 64'(gnt), 64'b01);
      step(); drive(0, 1, 0, 0, 5'd6, '0); drive(1, 1, 0, 1, 5'd4, '0);
      #3 check("t4_l0", 64'(gnt), 64'b10);
      step(); drive(1, 1, 1, 1, 5'd8, 32'hAABB_CCDD);
      #3 check("t4_l1", 64'(gnt), 64'b10);
      step(); drive(1, 1, 0, 0, 5'd8, '0);
      #3 check("t4_l2", 64'(gnt), 64'b10);
      step(); drive(1, 0, 0, 0, '0, '0);
      #3 check("t4_open", 64'(gnt), 64'b01);
      step(); drive(0, 0, 0, 0, '0, '0);
      step(); step();

      // Reset while a write to reg 7 is on the regfile port
      step(); drive(0, 1, 1, 0, 5'd7, 32'hCAFE_F00D);
      #3 check("t5_gnt", 64'(gnt), 64'b01);
      step(); drive(0, 0, 0, 0, '0, '0); reset = 1'b1;
      #3 check("t5_we", 64'(rf_we_), 64'd1);
      step(); reset = 1'b0; drive(0, 1, 0, 0, 5'd7, '0); drive(1, 1, 0, 0, 5'd2, '0);
      #3 check("t5_noack", 64'(ack), 64'd0);
      check("t5_ptr0", 64'(gnt), 64'b01);
      check("t5_reg7", 64'(rf_mem[7]), 64'(init_val(7)));
      step(); drive(0, 0, 0, 0, '0, '0);
      #3 check("t5_g1", 64'(gnt), 64'b10);
      step(); drive(1, 0, 0, 0, '0, '0);

      // Out-of-range write
      step(); drive(0, 1, 1, 0, 5'd20, 32'h0000_0055);
      #3 check("t6_gnt", 64'(gnt), 64'b01);
      step(); drive(0, 0, 0, 0, '0, '0);
      #3 check("t6_we", 64'(rf_we_), 64'd1);
      check("t6_rfaddr", 64'(rf_addr), 64'd0);
      step();
      #3 check("t6_ack", 64'(ack), 64'b01);
      check("t6_rdata", 64'(rdata), 64'd0);

      repeat (3) step();
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
